// File: rtl/sad_pkg.sv
// Shared types and helpers for the SAD winner-takes-all stage.
package sad_pkg;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_SCAN = 1'b1
  } state_e;

  // Index width that never collapses to zero bits for tiny candidate counts.
  function automatic int clog2_safe(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam int DEF_SAD_WIDTH  = 16;
  localparam int DEF_MAX_DISP   = 64;
  localparam int DEF_DISP_WIDTH = clog2_safe(DEF_MAX_DISP);

  // Result record at the default configuration, for consumers that pack/unpack the slot.
  typedef struct packed {
    logic [DEF_DISP_WIDTH-1:0] disp;
    logic [DEF_SAD_WIDTH-1:0]  sad;
    logic                      conf;
  } wta_result_t;

endpackage

// File: rtl/wta_cmp_unit.sv
// Combinational running min / second-min update for one candidate disparity.
module wta_cmp_unit #(
  parameter int SAD_WIDTH  = 16,
  parameter int DISP_WIDTH = 6
) (
  input  logic [SAD_WIDTH-1:0]  min_in,
  input  logic [SAD_WIDTH-1:0]  second_in,
  input  logic [DISP_WIDTH-1:0] best_d_in,
  input  logic [SAD_WIDTH-1:0]  sad_in,
  input  logic [DISP_WIDTH-1:0] d_in,
  output logic [SAD_WIDTH-1:0]  min_out,
  output logic [SAD_WIDTH-1:0]  second_out,
  output logic [DISP_WIDTH-1:0] best_d_out
);

  // Strict compare so an equal SAD never displaces the lower disparity.
  always_comb begin
    min_out    = min_in;
    second_out = second_in;
    best_d_out = best_d_in;
    if (sad_in < min_in) begin
      second_out = min_in;
      min_out    = sad_in;
      best_d_out = d_in;
    end else if (sad_in < second_in) begin
      second_out = sad_in;
    end else begin
      second_out = second_in;
    end
  end

endmodule

// File: rtl/sad_wta_select.sv
// Winner-takes-all disparity selection over MAX_DISP consecutive SADs,
// with a one-entry valid/ready output slot and sticky overrun flag.
module sad_wta_select
  import sad_pkg::*;
#(
  parameter int SAD_WIDTH   = 16,
  parameter int MAX_DISP    = 64,
  parameter int DISP_WIDTH  = clog2_safe(MAX_DISP),
  parameter int UNIQ_MARGIN = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  restart,
  input  logic [SAD_WIDTH-1:0]  sad_in,
  input  logic                  sad_valid,
  output logic [DISP_WIDTH-1:0] disp_out,
  output logic [SAD_WIDTH-1:0]  min_sad_out,
  output logic                  disp_conf,
  output logic                  disp_valid,
  input  logic                  disp_ready,
  output logic                  overrun,
  output logic                  busy
);

  localparam logic [DISP_WIDTH-1:0] LAST_D = DISP_WIDTH'(MAX_DISP - 1);
  localparam logic [SAD_WIDTH:0]    MARGIN = (SAD_WIDTH + 1)'(UNIQ_MARGIN);

  state_e                  r_state;
  state_e                  w_state_nxt;
  logic [DISP_WIDTH-1:0]   r_cnt;
  logic [DISP_WIDTH-1:0]   w_cnt_nxt;
  logic [SAD_WIDTH-1:0]    r_min;
  logic [SAD_WIDTH-1:0]    r_second;
  logic [DISP_WIDTH-1:0]   r_best_d;
  logic [SAD_WIDTH-1:0]    w_min_nxt;
  logic [SAD_WIDTH-1:0]    w_second_nxt;
  logic [DISP_WIDTH-1:0]   w_best_d_nxt;
  logic [SAD_WIDTH-1:0]    w_min_cmp;
  logic [SAD_WIDTH-1:0]    w_second_cmp;
  logic [DISP_WIDTH-1:0]   w_best_d_cmp;
  logic [SAD_WIDTH:0]      w_diff;
  logic                    w_conf;
  logic                    w_done;
  logic                    w_slot_free;

  logic [DISP_WIDTH-1:0]   r_disp;
  logic [SAD_WIDTH-1:0]    r_sad;
  logic                    r_conf;
  logic                    r_valid;
  logic                    r_overrun;
  logic                    r_busy;

  wta_cmp_unit #(
    .SAD_WIDTH  (SAD_WIDTH),
    .DISP_WIDTH (DISP_WIDTH)
  ) u_cmp (
    .min_in     (r_min),
    .second_in  (r_second),
    .best_d_in  (r_best_d),
    .sad_in     (sad_in),
    .d_in       (r_cnt),
    .min_out    (w_min_cmp),
    .second_out (w_second_cmp),
    .best_d_out (w_best_d_cmp)
  );

  // Second-min is never below min, so the extra bit only guards the all-ones case.
  assign w_diff      = {1'b0, w_second_cmp} - {1'b0, w_min_cmp};
  assign w_conf      = (w_diff >= MARGIN);
  assign w_slot_free = !r_valid || disp_ready;

  // Scan FSM: next state, candidate counter and running min/second/best.
  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_min_nxt    = r_min;
    w_second_nxt = r_second;
    w_best_d_nxt = r_best_d;
    w_done       = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (restart) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else if (sad_valid) begin
          w_min_nxt    = sad_in;
          w_second_nxt = '1;
          w_best_d_nxt = '0;
          w_cnt_nxt    = DISP_WIDTH'(1);
          w_state_nxt  = S_SCAN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_SCAN: begin
        if (restart) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end else if (sad_valid) begin
          w_min_nxt    = w_min_cmp;
          w_second_nxt = w_second_cmp;
          w_best_d_nxt = w_best_d_cmp;
          if (r_cnt == LAST_D) begin
            w_done      = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = S_IDLE;
          end else begin
            w_cnt_nxt = r_cnt + DISP_WIDTH'(1);
          end
        end else begin
          w_state_nxt = S_SCAN;
        end
      end
      default: begin
        w_cnt_nxt   = '0;
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State, counter and running comparison registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_min    <= '0;
      r_second <= '0;
      r_best_d <= '0;
      r_busy   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_min    <= w_min_nxt;
      r_second <= w_second_nxt;
      r_best_d <= w_best_d_nxt;
      r_busy   <= (w_cnt_nxt != '0);
    end
  end

  // One-entry output slot; a result arriving while it is stuck full is dropped.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_disp    <= '0;
      r_sad     <= '0;
      r_conf    <= 1'b0;
      r_valid   <= 1'b0;
      r_overrun <= 1'b0;
    end else if (w_done) begin
      if (w_slot_free) begin
        r_valid <= 1'b1;
        r_disp  <= w_best_d_cmp;
        r_sad   <= w_min_cmp;
        r_conf  <= w_conf;
      end else begin
        r_overrun <= 1'b1;
      end
    end else if (disp_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign disp_out    = r_disp;
  assign min_sad_out = r_sad;
  assign disp_conf   = r_conf;
  assign disp_valid  = r_valid;
  assign overrun     = r_overrun;
  assign busy        = r_busy;

endmodule

// File: tb/tb_sad_wta_select.sv
// Scoreboard bench for sad_wta_select at MAX_DISP = 4.
module tb_sad_wta_select;

  localparam int SW = 16;
  localparam int MD = 4;
  localparam int DW = 2;
  localparam int UM = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          restart;
  logic [SW-1:0] sad_in;
  logic          sad_valid;
  logic [DW-1:0] disp_out;
  logic [SW-1:0] min_sad_out;
  logic          disp_conf;
  logic          disp_valid;
  logic          disp_ready;
  logic          overrun;
  logic          busy;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [SW-1:0] sad;
    logic          conf;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_bad   = 0;

  sad_wta_select #(
    .SAD_WIDTH   (SW),
    .MAX_DISP    (MD),
    .UNIQ_MARGIN (UM)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .restart     (restart),
    .sad_in      (sad_in),
    .sad_valid   (sad_valid),
    .disp_out    (disp_out),
    .min_sad_out (min_sad_out),
    .disp_conf   (disp_conf),
    .disp_valid  (disp_valid),
    .disp_ready  (disp_ready),
    .overrun     (overrun),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  // Reference: global min, first index holding it, then min over the remaining indices.
  function automatic exp_t model(input logic [SW-1:0] a, b, c, e);
    logic [SW-1:0] v[4];
    int            mn;
    int            bd;
    int            sec;
    exp_t          r;
    v   = '{a, b, c, e};
    mn  = 32'h7fff_ffff;
    bd  = 0;
    sec = 32'h0000_ffff;
    for (int i = 0; i < 4; i++) if (int'(v[i]) < mn) mn = int'(v[i]);
    for (int i = 3; i >= 0; i--) if (int'(v[i]) == mn) bd = i;
    for (int i = 0; i < 4; i++) if (i != bd && int'(v[i]) < sec) sec = int'(v[i]);
    r.d    = DW'(bd);
    r.sad  = SW'(mn);
    r.conf = ((sec - mn) >= UM);
    return r;
  endfunction

  // Output monitor: every accepted slot is checked against the scoreboard head.
  always @(negedge clk) begin
    exp_t e;
    if (rst_n === 1'b1 && disp_valid === 1'b1 && disp_ready === 1'b1) begin
      n_total++;
      if (sb.size() == 0) begin
        n_bad++;
        $display("FAIL sb_unexpected: got d=%0d sad=%0d conf=%0d, no result expected",
                 disp_out, min_sad_out, disp_conf);
      end else begin
        e = sb.pop_front();
        if ({disp_out, min_sad_out, disp_conf} !== e) begin
          n_bad++;
          $display("FAIL sb_result: got d=%0d sad=%0d conf=%0d, expected d=%0d sad=%0d conf=%0d",
                   disp_out, min_sad_out, disp_conf, e.d, e.sad, e.conf);
        end
      end
    end
  end

  task automatic send_pixel(input logic [SW-1:0] a, b, c, e, input int gap, input bit push);
    logic [SW-1:0] v[4];
    v = '{a, b, c, e};
    if (push) sb.push_back(model(a, b, c, e));
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      sad_valid = 1'b1;
      sad_in    = v[i];
      if (i < 3) begin
        for (int g = 0; g < gap; g++) begin
          @(posedge clk); #1;
          sad_valid = 1'b0;
          sad_in    = SW'($urandom);
          n_total++;
          if (busy !== 1'b1) begin
            n_bad++;
            $display("FAIL gap_busy: got busy=%0b, expected 1", busy);
          end
        end
      end
    end
    @(posedge clk); #1;
    sad_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; restart = 1'b0; sad_valid = 1'b0; sad_in = '0; disp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if ({disp_valid, disp_out, min_sad_out, disp_conf, overrun, busy} !== '0) begin
      n_bad++;
      $display("FAIL reset_state: got v=%0b d=%0d sad=%0d c=%0b ovr=%0b busy=%0b, expected all 0",
               disp_valid, disp_out, min_sad_out, disp_conf, overrun, busy);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    disp_ready = 1'b1;
    send_pixel(16'd9, 16'd3, 16'd7, 16'd5, 0, 1'b1);
    n_total++;
    if ({disp_valid, disp_out, min_sad_out, disp_conf} !== {1'b1, 2'd1, 16'd3, 1'b0}) begin
      n_bad++;
      $display("FAIL basic_latency: got v=%0b d=%0d sad=%0d c=%0b, expected v=1 d=1 sad=3 c=0",
               disp_valid, disp_out, min_sad_out, disp_conf);
    end
    send_pixel(16'd20, 16'd6, 16'd6, 16'd30, 0, 1'b1);
    n_total++;
    if ({disp_out, min_sad_out, disp_conf} !== {2'd1, 16'd6, 1'b0}) begin
      n_bad++;
      $display("FAIL basic_tie: got d=%0d sad=%0d c=%0b, expected d=1 sad=6 c=0",
               disp_out, min_sad_out, disp_conf);
    end
    send_pixel(16'd20, 16'd2, 16'd15, 16'd30, 0, 1'b1);
    n_total++;
    if ({disp_out, min_sad_out, disp_conf} !== {2'd1, 16'd2, 1'b1}) begin
      n_bad++;
      $display("FAIL basic_conf: got d=%0d sad=%0d c=%0b, expected d=1 sad=2 c=1",
               disp_out, min_sad_out, disp_conf);
    end
    repeat (3) @(posedge clk);
    #1;
    n_total++;
    if (disp_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL basic_drain: got disp_valid=%0b, expected 0", disp_valid);
    end
  endtask

  task automatic test_overrun();
    disp_ready = 1'b0;
    send_pixel(16'd9, 16'd3, 16'd7, 16'd5, 0, 1'b1);
    n_total++;
    if ({disp_valid, overrun} !== 2'b10) begin
      n_bad++;
      $display("FAIL ovr_first: got v=%0b ovr=%0b, expected v=1 ovr=0", disp_valid, overrun);
    end
    send_pixel(16'd20, 16'd2, 16'd15, 16'd30, 0, 1'b0);
    n_total++;
    if ({disp_valid, disp_out, min_sad_out, disp_conf, overrun} !== {1'b1, 2'd1, 16'd3, 1'b0, 1'b1}) begin
      n_bad++;
      $display("FAIL ovr_hold: got v=%0b d=%0d sad=%0d c=%0b ovr=%0b, expected v=1 d=1 sad=3 c=0 ovr=1",
               disp_valid, disp_out, min_sad_out, disp_conf, overrun);
    end
    disp_ready = 1'b1;
    @(posedge clk); #1;
    n_total++;
    if ({disp_valid, overrun} !== 2'b01) begin
      n_bad++;
      $display("FAIL ovr_sticky: got v=%0b ovr=%0b, expected v=0 ovr=1", disp_valid, overrun);
    end
  endtask

  task automatic test_gaps();
    disp_ready = 1'b1;
    send_pixel(16'd9, 16'd3, 16'd7, 16'd5, 2, 1'b1);
    n_total++;
    if ({disp_valid, disp_out, min_sad_out, disp_conf, busy} !== {1'b1, 2'd1, 16'd3, 1'b0, 1'b0}) begin
      n_bad++;
      $display("FAIL gaps_result: got v=%0b d=%0d sad=%0d c=%0b busy=%0b, expected v=1 d=1 sad=3 c=0 busy=0",
               disp_valid, disp_out, min_sad_out, disp_conf, busy);
    end
  endtask

  task automatic test_restart();
    disp_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      sad_valid = 1'b1;
      sad_in    = 16'd1;
    end
    @(posedge clk); #1;
    restart   = 1'b1;
    sad_valid = 1'b1;
    sad_in    = 16'd0;
    @(posedge clk); #1;
    restart   = 1'b0;
    sad_valid = 1'b0;
    n_total++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL restart_busy: got busy=%0b, expected 0", busy);
    end
    send_pixel(16'd40, 16'd12, 16'd30, 16'd25, 0, 1'b1);
    n_total++;
    if ({disp_out, min_sad_out, disp_conf} !== {2'd1, 16'd12, 1'b1}) begin
      n_bad++;
      $display("FAIL restart_result: got d=%0d sad=%0d c=%0b, expected d=1 sad=12 c=1",
               disp_out, min_sad_out, disp_conf);
    end
  endtask

  task automatic test_reset_mid();
    @(posedge clk); #1;
    disp_ready = 1'b0;
    send_pixel(16'd9, 16'd3, 16'd7, 16'd5, 0, 1'b1);
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      sad_valid = 1'b1;
      sad_in    = 16'd1;
    end
    @(posedge clk); #1;
    sad_valid = 1'b0;
    rst_n     = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    n_total++;
    if ({disp_valid, disp_out, min_sad_out, disp_conf, overrun, busy} !== '0) begin
      n_bad++;
      $display("FAIL midreset_state: got v=%0b d=%0d sad=%0d c=%0b ovr=%0b busy=%0b, expected all 0",
               disp_valid, disp_out, min_sad_out, disp_conf, overrun, busy);
    end
    sb.delete();
    disp_ready = 1'b1;
    send_pixel(16'd20, 16'd6, 16'd6, 16'd30, 0, 1'b1);
    n_total++;
    if ({disp_valid, disp_out, min_sad_out} !== {1'b1, 2'd1, 16'd6}) begin
      n_bad++;
      $display("FAIL midreset_after: got v=%0b d=%0d sad=%0d, expected v=1 d=1 sad=6",
               disp_valid, disp_out, min_sad_out);
    end
    repeat (3) @(posedge clk);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_overrun();
    test_gaps();
    test_restart();
    test_reset_mid();
    #1;
    n_total++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL sb_leftover: got %0d results still pending, expected 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
